// File: rtl/uart_rx_fifo_if.sv
// Handshake bundle between the UART receiver, the receive FIFO and its consumer.
// UART_RX_FIFO_LEVEL_EN adds the o_level / o_almost_full status signals.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS  = 32,
    parameter int DEPTH_LOG2 = 4
);
    logic                  i_rx_done;
    logic [DATA_BITS-1:0]  i_rx_data;
    logic                  i_ready;
    logic                  i_clear_ovf;
    logic [DATA_BITS-1:0]  o_data;
    logic                  o_valid;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_overflow;
`ifdef UART_RX_FIFO_LEVEL_EN
    logic [DEPTH_LOG2:0]   o_level;
    logic                  o_almost_full;

    modport master (
        output i_rx_done, i_rx_data, i_ready, i_clear_ovf,
        input  o_data, o_valid, o_full, o_empty, o_overflow, o_level, o_almost_full
    );
    modport slave (
        input  i_rx_done, i_rx_data, i_ready, i_clear_ovf,
        output o_data, o_valid, o_full, o_empty, o_overflow, o_level, o_almost_full
    );
`else
    modport master (
        output i_rx_done, i_rx_data, i_ready, i_clear_ovf,
        input  o_data, o_valid, o_full, o_empty, o_overflow
    );
    modport slave (
        input  i_rx_done, i_rx_data, i_ready, i_clear_ovf,
        output o_data, o_valid, o_full, o_empty, o_overflow
    );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular first-word-fall-through FIFO capturing UART receiver words, with sticky overflow.
// Optional level/almost-full status is enabled by defining UART_RX_FIFO_LEVEL_EN.
module uart_rx_fifo #(
    parameter int DATA_BITS   = 32,
    parameter int DEPTH_LOG2  = 4,
    parameter int ALMOST_FULL = 12
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    uart_rx_fifo_if.slave        bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_BITS-1:0]  mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic valid, full, push, pop, drop;

    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);
    assign pop   = valid && bus.i_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts the word.
    assign push  = bus.i_rx_done && (!full || pop);
    assign drop  = bus.i_rx_done && full && !pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (drop)                 ovf_d = 1'b1;
        else if (bus.i_clear_ovf) ovf_d = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; only the pointers define what is live.
    always_ff @(posedge i_clk) begin
        if (push && !i_reset) mem_q[wr_ptr_q] <= bus.i_rx_data;
    end

    assign bus.o_data     = valid ? mem_q[rd_ptr_q] : '0;
    assign bus.o_valid    = valid;
    assign bus.o_empty    = !valid;
    assign bus.o_full     = full;
    assign bus.o_overflow = ovf_q;

    // Marker block that only elaborates for an out-of-range threshold.
    if (ALMOST_FULL < 1 || ALMOST_FULL > DEPTH) begin : g_almost_full_out_of_range
    end

`ifdef UART_RX_FIFO_LEVEL_EN
    localparam logic [DEPTH_LOG2:0] AF_CNT = (DEPTH_LOG2 + 1)'(ALMOST_FULL);
    assign bus.o_level       = count_q;
    assign bus.o_almost_full = (count_q >= AF_CNT);
`else
`endif
endmodule
